// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline flow controller: FSM encodings and ID/EXE bubble.
// No logic here; constants only.
// Imported by the controller, its detector and the pipeline registers.
package pipe_hazard_ctrl_pkg;

  // Controller states; state_dbg exports these values directly.
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_e;

  // Width of the load-use bubble counter (covers LOAD_STALLS up to 3).
  localparam int LU_CNT_W = 2;

  // Control fields of the ID/EXE register that must be cleared for a bubble.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [4:0] num_write;
  } id_exe_ctrl_t;

  // What ID/EXE loads when id_exe_flush is high.
  localparam id_exe_ctrl_t ID_EXE_BUBBLE = '{reg_write: 1'b0, mem_write: 1'b0, num_write: 5'd0};

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: ID reads a register the load in EXE is about to write.
// Purely combinational, zero latency.
// No backpressure; the controller decides what to do with lu_hit.
module load_use_detect (
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       use_rs_ID,
  input  logic       use_rt_ID,
  input  logic       mem_read_EXE,
  input  logic [4:0] num_write_EXE,
  output logic       lu_hit
);

  logic rs_match;
  logic rt_match;

  // Register $0 is never a real destination, so it never creates a hazard.
  always_comb begin
    rs_match = use_rs_ID && (rs_ID == num_write_EXE);
    rt_match = use_rt_ID && (rt_ID == num_write_EXE);
    lu_hit   = mem_read_EXE && (num_write_EXE != 5'd0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline flow controller: stall/flush/freeze decisions plus saturating perf counters.
// Control outputs are combinational from registered state and current inputs (0 cycles).
// Memory wait freezes the whole front end; load-use stalls PC and IF/ID only.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALLS = 2,
  parameter int PERF_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            rs_ID,
  input  logic [4:0]            rt_ID,
  input  logic                  use_rs_ID,
  input  logic                  use_rt_ID,
  input  logic                  mem_read_EXE,
  input  logic [4:0]            num_write_EXE,
  input  logic                  redirect_EXE,
  input  logic                  mem_access_MEM,
  input  logic                  dm_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_exe_en,
  output logic                  exe_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_exe_flush,
  output logic                  mem_wb_flush,
  output logic [PERF_WIDTH-1:0] stall_count,
  output logic [PERF_WIDTH-1:0] flush_count,
  output logic [1:0]            state_dbg
);

  localparam logic [LU_CNT_W-1:0] LU_INIT = LU_CNT_W'(LOAD_STALLS - 1);

  state_e                state_q, state_d, eff_state;
  logic [LU_CNT_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic [PERF_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [PERF_WIDTH-1:0] flush_count_q, flush_count_d;
  logic                  lu_hit;
  logic                  mem_wait;
  logic                  lu_active;

  load_use_detect u_lu_detect (
    .rs_ID         (rs_ID),
    .rt_ID         (rt_ID),
    .use_rs_ID     (use_rs_ID),
    .use_rt_ID     (use_rt_ID),
    .mem_read_EXE  (mem_read_EXE),
    .num_write_EXE (num_write_EXE),
    .lu_hit        (lu_hit)
  );

  // Priority decode: memory wait, then redirect, then load-use, then normal flow.
  // The release cycle of a memory wait is decoded as the state it returns to, so a
  // held EXE load or an owed bubble is honoured on that very cycle.
  always_comb begin
    mem_wait     = mem_access_MEM && !dm_ready;
    eff_state    = state_q;
    if (state_q == ST_MEM_WAIT) begin
      eff_state = (lu_cnt_q != '0) ? ST_LOAD_STALL : ST_RUN;
    end
    lu_active    = ((eff_state == ST_RUN) && lu_hit) ||
                   ((eff_state == ST_LOAD_STALL) && (lu_cnt_q != '0));
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_exe_en    = 1'b1;
    exe_mem_en   = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = ST_RUN;
    lu_cnt_d     = lu_cnt_q;
    if (mem_wait) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_exe_en    = 1'b0;
      exe_mem_en   = 1'b0;
      mem_wb_flush = 1'b1;
      state_d      = ST_MEM_WAIT;
    end else if (redirect_EXE) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
      lu_cnt_d     = '0;
    end else if (lu_active) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_exe_flush = 1'b1;
      lu_cnt_d     = (eff_state == ST_RUN) ? LU_INIT : lu_cnt_q - 1'b1;
      state_d      = (lu_cnt_d != '0) ? ST_LOAD_STALL : ST_RUN;
    end
    // While reset is held the pipeline must neither advance nor flush.
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_exe_en    = 1'b0;
      exe_mem_en   = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_exe_flush = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  // Saturating counters: stall cycles (pc held) and flush cycles (IF/ID squashed).
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!pc_en && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + PERF_WIDTH'(1);
    end
    if (if_id_flush && !(&flush_count_q)) begin
      flush_count_d = flush_count_q + PERF_WIDTH'(1);
    end
  end

  // State, bubble counter and perf counters; reset drops straight back to RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      lu_cnt_q      <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      lu_cnt_q      <= lu_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two controllers (LOAD_STALLS=2/PERF 32 and LOAD_STALLS=3/PERF 2)
// driven by directed scenarios and random traffic, compared against a bubble-debt model.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs_ID, rt_ID, num_write_EXE;
  logic       use_rs_ID, use_rt_ID, mem_read_EXE, redirect_EXE, mem_access_MEM, dm_ready;

  logic        a_pc_en, a_if_id_en, a_id_exe_en, a_exe_mem_en, a_mem_wb_en;
  logic        a_if_id_flush, a_id_exe_flush, a_mem_wb_flush;
  logic [31:0] a_stall_count, a_flush_count;
  logic [1:0]  a_state_dbg;
  logic        b_pc_en, b_if_id_en, b_id_exe_en, b_exe_mem_en, b_mem_wb_en;
  logic        b_if_id_flush, b_id_exe_flush, b_mem_wb_flush;
  logic [1:0]  b_stall_count, b_flush_count;
  logic [1:0]  b_state_dbg;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.LOAD_STALLS(2), .PERF_WIDTH(32)) dut_a (
    .clock(clock), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID), .mem_read_EXE(mem_read_EXE),
    .num_write_EXE(num_write_EXE), .redirect_EXE(redirect_EXE),
    .mem_access_MEM(mem_access_MEM), .dm_ready(dm_ready),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_exe_en(a_id_exe_en),
    .exe_mem_en(a_exe_mem_en), .mem_wb_en(a_mem_wb_en), .if_id_flush(a_if_id_flush),
    .id_exe_flush(a_id_exe_flush), .mem_wb_flush(a_mem_wb_flush),
    .stall_count(a_stall_count), .flush_count(a_flush_count), .state_dbg(a_state_dbg)
  );

  pipe_hazard_ctrl #(.LOAD_STALLS(3), .PERF_WIDTH(2)) dut_b (
    .clock(clock), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID), .mem_read_EXE(mem_read_EXE),
    .num_write_EXE(num_write_EXE), .redirect_EXE(redirect_EXE),
    .mem_access_MEM(mem_access_MEM), .dm_ready(dm_ready),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_exe_en(b_id_exe_en),
    .exe_mem_en(b_exe_mem_en), .mem_wb_en(b_mem_wb_en), .if_id_flush(b_if_id_flush),
    .id_exe_flush(b_id_exe_flush), .mem_wb_flush(b_mem_wb_flush),
    .stall_count(b_stall_count), .flush_count(b_flush_count), .state_dbg(b_state_dbg)
  );

  logic [7:0] a_ctl, b_ctl;
  assign a_ctl = {a_pc_en, a_if_id_en, a_id_exe_en, a_exe_mem_en, a_mem_wb_en,
                  a_if_id_flush, a_id_exe_flush, a_mem_wb_flush};
  assign b_ctl = {b_pc_en, b_if_id_en, b_id_exe_en, b_exe_mem_en, b_mem_wb_en,
                  b_if_id_flush, b_id_exe_flush, b_mem_wb_flush};

  int checks = 0;
  int errors = 0;

  // Reference model: bubbles still owed, expected state, counts (index 0 = A, 1 = B).
  int         owed[2];
  logic [1:0] exp_state[2];
  longint     exp_stall[2];
  longint     exp_flush[2];
  int         cfg_ls[2]   = '{2, 3};
  longint     cfg_max[2]  = '{64'hFFFF_FFFF, 64'd3};
  int         a_pc_low = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control vector and bookkeeping for one instance in the current cycle.
  function automatic logic [7:0] model_ctl(input int i, output int nowed, output logic [1:0] nstate);
    logic hit;
    logic [7:0] c;
    hit = mem_read_EXE && (num_write_EXE != 0) &&
          ((use_rs_ID && rs_ID == num_write_EXE) || (use_rt_ID && rt_ID == num_write_EXE));
    nowed = owed[i];
    if (mem_access_MEM && !dm_ready) begin
      c = 8'b0000_1001;
      nstate = 2'd2;
    end else begin
      if (redirect_EXE) begin
        c = 8'b1111_1110;
        nowed = 0;
      end else if (owed[i] > 0) begin
        c = 8'b0011_1010;
        nowed = owed[i] - 1;
      end else if (hit) begin
        c = 8'b0011_1010;
        nowed = cfg_ls[i] - 1;
      end else begin
        c = 8'b1111_1000;
      end
      nstate = (nowed > 0) ? 2'd1 : 2'd0;
    end
    if (!reset) begin
      c = 8'h00;
      nowed = 0;
      nstate = 2'd0;
    end
    return c;
  endfunction

  // One clock: inputs already set at the falling edge; check, then advance the model.
  task automatic cycle(input string tag);
    logic [7:0] ec[2];
    int         no[2];
    logic [1:0] ns[2];
    #1;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        owed[i] = 0; exp_state[i] = 2'd0; exp_stall[i] = 0; exp_flush[i] = 0;
      end
    end
    for (int i = 0; i < 2; i++) ec[i] = model_ctl(i, no[i], ns[i]);
    chk({tag, ".a_ctl"},   {56'd0, a_ctl},         {56'd0, ec[0]});
    chk({tag, ".b_ctl"},   {56'd0, b_ctl},         {56'd0, ec[1]});
    chk({tag, ".a_state"}, {62'd0, a_state_dbg},   {62'd0, exp_state[0]});
    chk({tag, ".b_state"}, {62'd0, b_state_dbg},   {62'd0, exp_state[1]});
    chk({tag, ".a_stall"}, {32'd0, a_stall_count}, exp_stall[0]);
    chk({tag, ".a_flush"}, {32'd0, a_flush_count}, exp_flush[0]);
    chk({tag, ".b_stall"}, {62'd0, b_stall_count}, exp_stall[1]);
    chk({tag, ".b_flush"}, {62'd0, b_flush_count}, exp_flush[1]);
    if (reset && !a_pc_en) a_pc_low++;
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        owed[i] = no[i];
        exp_state[i] = ns[i];
        if (!ec[i][7] && exp_stall[i] < cfg_max[i]) exp_stall[i]++;
        if (ec[i][2] && exp_flush[i] < cfg_max[i]) exp_flush[i]++;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    rs_ID = 5'd0; rt_ID = 5'd0; num_write_EXE = 5'd0;
    use_rs_ID = 1'b0; use_rt_ID = 1'b0; mem_read_EXE = 1'b0;
    redirect_EXE = 1'b0; mem_access_MEM = 1'b0; dm_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b0;
    cycle("rst");
    reset = 1'b1;
    a_pc_low = 0;
  endtask

  initial begin
    idle();
    for (int i = 0; i < 2; i++) begin
      owed[i] = 0; exp_state[i] = 2'd0; exp_stall[i] = 0; exp_flush[i] = 0;
    end
    @(negedge clock);
    cycle("reset0");
    cycle("reset1");
    reset = 1'b1;
    cycle("first_run");

    // lw $1 ; add $2,$1,$3
    pulse_reset();
    mem_read_EXE = 1'b1; num_write_EXE = 5'd1; rs_ID = 5'd1; rt_ID = 5'd3;
    use_rs_ID = 1'b1; use_rt_ID = 1'b1;
    cycle("lu_hit");
    idle();
    for (int k = 0; k < 4; k++) cycle("lu_after");
    chk("lu_pc_low_cycles", 64'(a_pc_low), 64'd2);
    chk("lu_stall_a", {32'd0, a_stall_count}, 64'd2);
    chk("lu_stall_b_sat", {62'd0, b_stall_count}, 64'd3);

    // load to $0, reader of $0
    pulse_reset();
    mem_read_EXE = 1'b1; num_write_EXE = 5'd0; rs_ID = 5'd0; use_rs_ID = 1'b1;
    cycle("lu_r0");
    idle();
    cycle("lu_r0_after");
    chk("lu_r0_stall", {32'd0, a_stall_count}, 64'd0);

    // redirect with a simultaneous load-use hit
    pulse_reset();
    redirect_EXE = 1'b1; mem_read_EXE = 1'b1; num_write_EXE = 5'd4; rt_ID = 5'd4; use_rt_ID = 1'b1;
    cycle("redir_lu");
    idle();
    cycle("redir_after");
    chk("redir_flush_count", {32'd0, a_flush_count}, 64'd1);
    chk("redir_state", {62'd0, a_state_dbg}, 64'd0);

    // store in MEM, memory slow for 3 cycles
    pulse_reset();
    mem_access_MEM = 1'b1; dm_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle("mw");
    dm_ready = 1'b1;
    cycle("mw_release");
    idle();
    cycle("mw_after");
    chk("mw_stall", {32'd0, a_stall_count}, 64'd3);

    // memory wait landing inside a load-use stall
    pulse_reset();
    mem_read_EXE = 1'b1; num_write_EXE = 5'd7; rs_ID = 5'd7; use_rs_ID = 1'b1;
    cycle("lumw_hit");
    idle();
    mem_access_MEM = 1'b1; dm_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle("lumw_wait");
    dm_ready = 1'b1; mem_access_MEM = 1'b0;
    for (int k = 0; k < 3; k++) cycle("lumw_after");
    chk("lumw_pc_low", 64'(a_pc_low), 64'd5);

    // reset between edges in the middle of a wait
    pulse_reset();
    mem_access_MEM = 1'b1; dm_ready = 1'b0;
    cycle("rmw_wait0");
    cycle("rmw_wait1");
    #2 reset = 1'b0;
    #1;
    chk("rmw_state_now", {62'd0, a_state_dbg}, 64'd0);
    chk("rmw_stall_now", {32'd0, a_stall_count}, 64'd0);
    @(negedge clock);
    cycle("rmw_held");
    reset = 1'b1;
    idle();
    cycle("rmw_release");
    cycle("rmw_release2");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rs_ID          = 5'($urandom_range(0, 3));
      rt_ID          = 5'($urandom_range(0, 3));
      num_write_EXE  = 5'($urandom_range(0, 3));
      use_rs_ID      = 1'($urandom_range(0, 1));
      use_rt_ID      = 1'($urandom_range(0, 1));
      mem_read_EXE   = 1'($urandom_range(0, 1));
      redirect_EXE   = ($urandom_range(0, 7) == 0);
      mem_access_MEM = ($urandom_range(0, 2) == 0);
      dm_ready       = ($urandom_range(0, 2) != 0);
      reset          = ($urandom_range(0, 63) != 0);
      cycle("rand");
    end

    // saturation of the narrow counters
    reset = 1'b1; idle();
    mem_access_MEM = 1'b1; dm_ready = 1'b0;
    for (int k = 0; k < 6; k++) cycle("sat");
    chk("sat_b_stall", {62'd0, b_stall_count}, 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline flow controller for the 5-stage pipelined CPU. It decides every cycle which pipeline registers advance, hold or load a bubble. It covers three cases: load-use interlock, taken-branch/jump flush resolved in EXE, and freezing the pipeline while a slow data memory completes an access. It sits beside the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers and drives their enable/flush inputs and the PC enable; it also keeps saturating stall/flush performance counters.

## Interface
Parameters:
- LOAD_STALLS, 2, bubbles inserted per load-use hazard. Load data reaches forwarding only from WB; legal 1..3.
- PERF_WIDTH, 32, width of each performance counter.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- rs_ID, rt_ID  in  5 each  source register numbers in ID
- use_rs_ID, use_rt_ID  in  1 each  ID instruction actually reads rs / rt
- mem_read_EXE  in  1  EXE instruction is a load
- num_write_EXE  in  5  EXE destination register
- redirect_EXE  in  1  taken branch/jump resolved in EXE
- mem_access_MEM  in  1  MEM instruction is a load or store
- dm_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC loads next PC
- if_id_en, id_exe_en, exe_mem_en, mem_wb_en  out  1 each  register loads
- if_id_flush  out  1  IF/ID loads NOP
- id_exe_flush  out  1  ID/EXE loads bubble (reg_write=0, mem_write=0, num_write=0)
- mem_wb_flush  out  1  MEM/WB loads bubble
- stall_count, flush_count  out  PERF_WIDTH each  saturating counters
- state_dbg  out  2  current FSM state

## Operation
- States: RUN, LOAD_STALL, MEM_WAIT. An internal counter lu_cnt (2 bits) tracks load-use bubbles.
- Hazard detect: lu_hit = mem_read_EXE && num_write_EXE!=0 && ((use_rs_ID && rs_ID==num_write_EXE) || (use_rt_ID && rt_ID==num_write_EXE)).
- mem_wait = mem_access_MEM && !dm_ready.
- Priority, evaluated every cycle in any state: mem_wait > redirect_EXE > load-use > normal.
- mem_wait:
  - pc_en, if_id_en, id_exe_en, exe_mem_en = 0.
  - mem_wb_flush = 1.
  - Next state MEM_WAIT; lu_cnt frozen.
  - A redirect_EXE seen during the wait is ignored; EXE holds, so it is re-seen on release.
- redirect_EXE (no mem_wait):
  - All enables = 1; if_id_flush = id_exe_flush = 1.
  - Next state RUN; lu_cnt cleared; a pending load-use is discarded.
- Load-use (RUN && lu_hit, or LOAD_STALL with lu_cnt!=0):
  - pc_en = if_id_en = 0.
  - id_exe_flush = 1; the exe_mem and mem_wb enables stay 1.
  - Entry from RUN sets lu_cnt = LOAD_STALLS-1.
  - In LOAD_STALL, lu_cnt decrements each cycle; the state returns to RUN on the cycle lu_cnt reaches 0.
  - With LOAD_STALLS=1 the FSM never leaves RUN.
- MEM_WAIT exit: when dm_ready is asserted, the state returns to LOAD_STALL if lu_cnt!=0, else RUN, and that cycle's outputs follow normal priority.
- Normal: all enables 1, all flushes 0.
- Counters:
  - stall_count +1 each cycle pc_en=0 and reset is high.
  - flush_count +1 each cycle if_id_flush=1.
  - Both saturate at 2^PERF_WIDTH-1.
- reset low (asynchronous): state RUN, lu_cnt 0, counters 0. Enables 0, flushes 0 while reset is asserted. Pipeline registers reset themselves.

## Timing
- All control outputs are combinational (Mealy) from the registered state/lu_cnt and the current inputs; they take effect at the next clock edge with zero added latency.
- State, lu_cnt and counters update on the rising clock edge.
- Load-use costs exactly LOAD_STALLS cycles with pc_en=0. Redirect costs 2 flushed slots. A memory wait costs N cycles for N cycles of dm_ready low.
- Reset mid-stall or mid-wait: immediate return to RUN, counters cleared; no residual stall after release.
- Reset deassertion: the first cycle after release behaves as RUN.

## Structure
- Shared package/header:
  - state encodings ST_RUN=0, ST_LOAD_STALL=1, ST_MEM_WAIT=2.
  - the bubble encoding for ID/EXE control fields.
- Sub-module load_use_detect: purely combinational, producing lu_hit. The top holds the FSM, output decode and counters.

## Test plan
- `lw $1` followed by `add $2,$1,$3`, dm_ready=1 → pc_en low exactly 2 cycles; id_exe_flush high the same 2 cycles; stall_count=2.
- Load to $0 followed by a reader of $0 → no stall; stall_count=0.
- redirect_EXE pulsed with lu_hit asserted the same cycle → if_id_flush=id_exe_flush=1, pc_en=1, state RUN, flush_count=1.
- Store in MEM, dm_ready low 3 cycles → front four enables low 3 cycles, mem_wb_flush high 3 cycles, stall_count=3; resumes on the 4th cycle.
- dm_ready drops during LOAD_STALL with lu_cnt=1 → MEM_WAIT held; on release 1 further load-use bubble; total pc_en-low = wait cycles + 2.
- reset pulsed low mid-MEM_WAIT (between edges) → state_dbg=0 and counters=0 immediately; outputs normal after release; saturation checked with PERF_WIDTH=2 (counter stays 3).
